// File: rtl/md_unit.sv
// md_unit: iterative radix-2 multiply/divide unit owning the HI/LO registers
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   start_e_i  execute-stage MD op present (qualified by op_e_i)
//   op_e_i     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//   src_a_e_i  rs: multiplicand / dividend / MTHI-MTLO data
//   src_b_e_i  rt: multiplier / divisor
//   flush_e_i  execute-stage flush, blocks acceptance in the same cycle
//   busy_o     registered stall request while an op is in flight
//   done_o     one-cycle pulse in the first cycle HI/LO show a MULT/DIV result
//   hi_o/lo_o  HI and LO registers
//
// Optional build macro MD_FAST_MUL_EN: MULT/MULTU finish at the accept edge
// through a combinational multiplier and the MUL state is never entered.
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_e_i,
    input  logic [2:0]       op_e_i,
    input  logic [WIDTH-1:0] src_a_e_i,
    input  logic [WIDTH-1:0] src_b_e_i,
    input  logic             flush_e_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] dvs, dvs_n, hi_n, lo_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic is_div, is_div_n, neg_q, neg_q_n, neg_r, neg_r_n, busy_n, done_n;
    logic accept, sgn_op, q_sign, r_sign, last;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign accept = start_e_i && !flush_e_i && state == IDLE;
    assign sgn_op = !op_e_i[0];
    assign mag_a  = (sgn_op && src_a_e_i[WIDTH-1]) ? -src_a_e_i : src_a_e_i;
    assign mag_b  = (sgn_op && src_b_e_i[WIDTH-1]) ? -src_b_e_i : src_b_e_i;
    assign q_sign = sgn_op && (src_a_e_i[WIDTH-1] ^ src_b_e_i[WIDTH-1]);
    assign r_sign = sgn_op && src_a_e_i[WIDTH-1];
    assign last   = cnt == {CNT_W{1'b1}};
    // Restoring division: acc holds {remainder, dividend-shifting-into-quotient}.
    logic [WIDTH:0] div_sh, div_df;
    logic div_ok;
    logic [2*WIDTH-1:0] div_nx;
    assign div_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_df = div_sh - {1'b0, dvs};
    assign div_ok = !div_df[WIDTH];
    assign div_nx = {div_ok ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0], acc[WIDTH-2:0], div_ok};
`ifdef MD_FAST_MUL_EN
    logic [2*WIDTH-1:0] fm_abs, fm;
    assign fm_abs = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    assign fm     = q_sign ? -fm_abs : fm_abs;
`else
    // Shift-add multiply: acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0] mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};
`endif
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem;
    assign prod = neg_q ? -acc : acc;
    assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        dvs_n    = dvs;
        cnt_n    = cnt;
        hi_n     = hi_o;
        lo_n     = lo_o;
        is_div_n = is_div;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_e_i)
                        3'b000, 3'b001: begin
`ifdef MD_FAST_MUL_EN
                            {hi_n, lo_n} = fm;
                            done_n       = 1'b1;
`else
                            state_n  = MUL;
                            acc_n    = {{WIDTH{1'b0}}, mag_a};
                            dvs_n    = mag_b;
                            cnt_n    = '0;
                            is_div_n = 1'b0;
                            neg_q_n  = q_sign;
                            neg_r_n  = 1'b0;
`endif
                        end
                        3'b010, 3'b011: begin
                            if (src_b_e_i == '0) begin
                                lo_n   = '1;
                                hi_n   = src_a_e_i;
                                done_n = 1'b1;
                            end else begin
                                state_n  = DIV;
                                acc_n    = {{WIDTH{1'b0}}, mag_a};
                                dvs_n    = mag_b;
                                cnt_n    = '0;
                                is_div_n = 1'b1;
                                neg_q_n  = q_sign;
                                neg_r_n  = r_sign;
                            end
                        end
                        3'b100: hi_n = src_a_e_i;
                        3'b101: lo_n = src_a_e_i;
                        default: ;
                    endcase
                end
            end
`ifndef MD_FAST_MUL_EN
            MUL: begin
                acc_n   = mul_nx;
                cnt_n   = cnt + CNT_W'(1);
                state_n = last ? FIX : MUL;
            end
`endif
            DIV: begin
                acc_n   = div_nx;
                cnt_n   = cnt + CNT_W'(1);
                state_n = last ? FIX : DIV;
            end
            FIX: begin
                state_n = IDLE;
                done_n  = 1'b1;
                hi_n    = is_div ? rem : prod[2*WIDTH-1:WIDTH];
                lo_n    = is_div ? quot : prod[WIDTH-1:0];
            end
            default: state_n = IDLE;
        endcase
    end
    assign busy_n = state_n != IDLE;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            acc    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            dvs    <= dvs_n;
            cnt    <= cnt_n;
            hi_o   <= hi_n;
            lo_o   <= lo_n;
            is_div <= is_div_n;
            neg_q  <= neg_q_n;
            neg_r  <= neg_r_n;
            busy_o <= busy_n;
            done_o <= done_n;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;
    localparam int W = 32;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;
`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = W + 1;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, flush = 1'b0;
    logic [2:0] op = 3'd0;
    logic [W-1:0] src_a = '0, src_b = '0;
    logic busy, done;
    logic [W-1:0] hi, lo;
    md_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .start_e_i(start), .op_e_i(op),
        .src_a_e_i(src_a), .src_b_e_i(src_b), .flush_e_i(flush),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int lat;
        int cyc;
    } exp_t;
    exp_t q[$];
    logic [W-1:0] arch_hi = '0, arch_lo = '0;
    logic aborted = 1'b0;
    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    // Reference model: plain 64-bit arithmetic, SV division truncates toward zero.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l);
        longint p;
        logic [63:0] u;
        h = arch_hi;
        l = arch_lo;
        if (o == MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            u = 64'(p);
            {h, l} = u;
        end else if (o == MULTU) begin
            u = {32'b0, a} * {32'b0, b};
            {h, l} = u;
        end else if ((o == DIV || o == DIVU) && b == 0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (o == DIV) begin
            p = longint'($signed(a)) / longint'($signed(b));
            l = p[31:0];
            p = longint'($signed(a)) % longint'($signed(b));
            h = p[31:0];
        end else if (o == DIVU) begin
            l = a / b;
            h = a % b;
        end
    endtask
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic fl);
        int n = 0;
        exp_t e;
        logic [W-1:0] h, l;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("issue_wait_busy", 64'(busy), 64'(0));
        start = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        if (!fl) begin
            if (o <= DIVU) begin
                model(o, a, b, h, l);
                e.hi = h;
                e.lo = l;
                e.lat = (o <= MULTU) ? MUL_LAT : (b == 0 ? 0 : W + 1);
                e.cyc = cyc;
                q.push_back(e);
            end else if (o == MTHI) arch_hi = a;
            else if (o == MTLO) arch_lo = a;
        end
    endtask
    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", 64'(q.size()), 64'(0));
    endtask
    function automatic logic [W-1:0] pick();
        int s = $urandom_range(0, 6);
        return s == 0 ? 32'h0 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'h8000_0000 :
               s == 3 ? 32'($urandom_range(0, 20)) : s == 4 ? -32'($urandom_range(1, 20)) : 32'($urandom);
    endfunction
    // Monitor: pops on done_o, and tracks HI/LO and busy run length every cycle.
    initial begin
        exp_t e;
        int run = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("done_hi", 64'(hi), 64'(e.hi));
                    chk("done_lo", 64'(lo), 64'(e.lo));
                    chk("done_latency", 64'(cyc - e.cyc), 64'(e.lat));
                    chk("busy_at_done", 64'(busy), 64'(0));
                    arch_hi = e.hi;
                    arch_lo = e.lo;
                end
            end
            chk("hold_hi", 64'(hi), 64'(arch_hi));
            chk("hold_lo", 64'(lo), 64'(arch_lo));
            if (busy) run++;
            else if (run != 0) begin
                if (!aborted) chk("busy_cycles", 64'(run), 64'(W + 1));
                run = 0;
                aborted = 1'b0;
            end
        end
    end
    initial begin
        logic [2:0] o;
        logic [W-1:0] a, b;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        issue(DIV, -32'd7, 32'd2, 1'b0);
        issue(DIVU, 32'd100, 32'd7, 1'b0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(DIVU, 32'd5, 32'd0, 1'b0);
        issue(MTHI, 32'h1234_5678, 32'd0, 1'b0);
        issue(MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
        issue(MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue(DIVU, 32'd9, 32'd0, 1'b1);
        issue(MULT, 32'd3, 32'd4, 1'b1);
        drain();
        issue(DIVU, 32'hFFFF_0000, 32'd3, 1'b0);
        repeat (5) begin
            @(negedge clk);
            start = 1'b1;
            op = MTLO;
            src_a = $urandom;
            src_b = 32'd0;
        end
        @(negedge clk);
        start = 1'b0;
        drain();
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            issue(o, a, b, $urandom_range(0, 7) == 0);
        end
        drain();
        issue(DIV, 32'h7654_3210, 32'd13, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        arch_hi = '0;
        arch_lo = '0;
        aborted = 1'b1;
        #1;
        chk("midop_reset_busy", 64'(busy), 64'(0));
        chk("midop_reset_done", 64'(done), 64'(0));
        chk("midop_reset_hi", 64'(hi), 64'(0));
        chk("midop_reset_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(MULT, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b0);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit in the execute stage; owns the HI/LO registers.
- It is the requesting side of the stall/flush interface.
  - It receives the execute-stage flush from the hazard handler.
  - It returns a busy stall request, which the hazard handler ORs into stall_f/stall_d/flush_e while a result is pending.
- Radix-2: one result bit per cycle; signed results are obtained by magnitude arithmetic plus a final sign fix.

Parameters:
- WIDTH, 32, operand and HI/LO width; fixed at 32 for MIPS, parameterised for the bench only.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_e_i  in  1  execute-stage instruction is an MD op; qualified by op_e_i.
- op_e_i  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - Other codes are no-ops.
- src_a_e_i  in  WIDTH  rs value: multiplicand / dividend / MTHI-MTLO data.
- src_b_e_i  in  WIDTH  rt value: multiplier / divisor.
- flush_e_i  in  1  execute-stage flush from the hazard handler.
- busy_o  out  1  registered stall request: operation in flight.
- done_o  out  1  one-cycle pulse: HI/LO just updated by a MULT/DIV.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0, internal datapath regs=0.
  - Reset mid-operation discards the in-flight result; HI/LO still read 0.
- Accept rule: an op is accepted at a rising edge only when start_e_i=1, flush_e_i=0 and state=IDLE.
  - start_e_i while busy is ignored; the hazard handler guarantees a stall.
  - flush_e_i=1 blocks acceptance in that same cycle.
  - flush_e_i does not abort an op already accepted; that instruction has left E.
- MTHI/MTLO: HI or LO is written with src_a_e_i at the accept edge. busy_o stays 0 and done_o stays 0.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE -> MUL on accepted MULT/MULTU.
  - Latch |a|, |b| for signed ops; raw a and b for unsigned.
  - Latch result sign = a[31]^b[31] (signed only).
  - Counter = 0.
- IDLE -> DIV on accepted DIV/DIVU with src_b_e_i != 0.
  - Latch magnitudes as above.
  - Latch quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only).
- Division by zero does not enter DIV.
  - At the accept edge: LO = 32'hFFFF_FFFF, HI = src_a_e_i.
  - busy_o never rises; done_o pulses in the next cycle.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator; after WIDTH steps (counter wraps 31 -> 0), go to FIX.
- DIV: one restoring shift-subtract step per cycle, yielding a WIDTH-bit quotient and remainder; after WIDTH steps, go to FIX.
- FIX:
  - Apply two's-complement negation per the latched signs.
  - Write HI/LO: multiply HI=product[63:32], LO=product[31:0]; divide LO=quotient, HI=remainder.
  - Return to IDLE.
- Quotient truncates toward zero; remainder takes the dividend's sign.
- -2^31 / -1 gives LO=32'h8000_0000, HI=0; no trap.
- busy_o = registered (state != IDLE).
  - It is high for exactly WIDTH+1 = 33 cycles, starting the cycle after the accept edge.
- done_o is registered: high for the single cycle after the FIX edge, i.e. the first cycle hi_o/lo_o show the new result.
  - busy_o is 0 in that cycle, so back-to-back MD ops are possible.
- hi_o/lo_o hold their old values throughout MUL/DIV/FIX; they change only at the FIX edge or at an MTHI/MTLO accept.

Optional Feature:
- Macro MD_FAST_MUL_EN.
- Defined:
  - MULT/MULTU complete at the accept edge using a combinational 64-bit multiply; HI/LO are written then.
  - busy_o stays 0; done_o pulses in the next cycle.
  - The MUL state is not built.
  - DIV behaviour is unchanged.
- Undefined: iterative 33-cycle multiply as above.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF:
  - busy_o high 33 cycles.
  - Then HI=32'hFFFF_FFFE, LO=32'h0000_0001, with done_o 1 cycle.
  - With MD_FAST_MUL_EN: same result after 1 cycle, busy_o never 1.
- MULT a=-3 (32'hFFFF_FFFD), b=7 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- DIV a=-7, b=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
- DIVU a=100, b=7 -> LO=14, HI=2.
- DIV a=-2^31, b=-1 -> LO=32'h8000_0000, HI=0.
- DIVU a=5, b=0 -> LO=32'hFFFF_FFFF, HI=5, busy_o never 1, done_o next cycle.
- MTHI 32'h1234_5678 then MTLO 32'h9ABC_DEF0 -> registers updated at each accept edge; busy_o and done_o stay 0.
- start_e_i=1 with flush_e_i=1 -> nothing accepted, HI/LO unchanged.
- start_e_i pulsed again during busy -> ignored; the original result is written.
- rst_ni low at cycle 10 of a DIV -> async return to IDLE; HI/LO/busy/done=0; no done pulse afterwards.
